// File: rtl/ula_issue.sv
// ula_issue: single-issue sequencer that reads the register bank, drives the ALU
// and hands the result to writeback through a valid/ready handshake.
module ula_issue #(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_op,
  input  logic [3:0]      in_ra,
  input  logic [3:0]      in_rb,
  input  logic [3:0]      in_rd,
  input  logic [bits-1:0] in_const,
  output logic [3:0]      rf_ra,
  output logic [3:0]      rf_rb,
  input  logic [bits-1:0] rf_da,
  input  logic [bits-1:0] rf_db,
  output logic [bits-1:0] ula_a,
  output logic [bits-1:0] ula_b,
  output logic [7:0]      ula_op,
  input  logic [bits-1:0] ula_resu,
  input  logic            ula_o,
  input  logic            ula_c,
  input  logic            ula_s,
  input  logic            ula_z,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [3:0]      wb_rd,
  output logic [bits-1:0] wb_data,
  output logic            flag_o,
  output logic            flag_c,
  output logic            flag_s,
  output logic            flag_z,
  output logic            err,
  output logic [15:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  state_t state, nxt;

  logic [7:0]      op_q;
  logic [3:0]      ra_q;
  logic [3:0]      rb_q;
  logic [3:0]      rd_q;
  logic [bits-1:0] const_q;
  logic [bits-1:0] a_q;
  logic [bits-1:0] b_q;
  logic [7:0]      uop_q;
  logic [bits-1:0] res_q;
  logic [3:0]      flags_q;
  logic            err_q;
  logic [15:0]     cnt_q;
  logic            bad;
  logic            take;

  assign bad  = (in_op[7:6] == 2'b11);
  assign take = (state == IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (in_valid && !bad) nxt = READ;
      READ: nxt = EXEC;
      EXEC: nxt = WB;
      WB:   if (wb_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      const_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      uop_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // illegal formats are consumed here and never reach READ
      err_q <= take && bad;
      if (take && !bad) begin
        op_q    <= in_op;
        ra_q    <= in_ra;
        rb_q    <= in_rb;
        rd_q    <= in_rd;
        const_q <= in_const;
      end
      if (state == READ) begin
        a_q   <= rf_da;
        b_q   <= (op_q[7:6] == 2'b10) ? rf_db : const_q;
        uop_q <= op_q;
      end
      if (state == EXEC) begin
        res_q <= ula_resu;
        if (op_q[7:6] == 2'b10)
          flags_q <= {ula_o, ula_c, ula_s, ula_z};
      end
      if (state == WB && wb_ready)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign in_ready = (state == IDLE);
  assign wb_valid = (state == WB);
  assign rf_ra    = ra_q;
  assign rf_rb    = rb_q;
  assign ula_a    = a_q;
  assign ula_b    = b_q;
  assign ula_op   = uop_q;
  assign wb_rd    = rd_q;
  assign wb_data  = res_q;
  assign flag_o   = flags_q[3];
  assign flag_c   = flags_q[2];
  assign flag_s   = flags_q[1];
  assign flag_z   = flags_q[0];
  assign err      = err_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_ula_issue.sv
// tb_ula_issue: directed literal cases plus randomized traffic checked every
// cycle against a transaction-level model of the issue pipeline.
module tb_ula_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [3:0]  in_ra, in_rb, in_rd;
  logic [15:0] in_const;
  logic [3:0]  rf_ra, rf_rb;
  logic [15:0] rf_da, rf_db;
  logic [15:0] ula_a, ula_b;
  logic [7:0]  ula_op;
  logic [15:0] ula_resu;
  logic        ula_o, ula_c, ula_s, ula_z;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flag_o, flag_c, flag_s, flag_z;
  logic        err;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf [16];

  ula_issue #(.bits(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .in_const(in_const),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_da(rf_da), .rf_db(rf_db),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_resu(ula_resu),
    .ula_o(ula_o), .ula_c(ula_c), .ula_s(ula_s), .ula_z(ula_z),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_o(flag_o), .flag_c(flag_c), .flag_s(flag_s), .flag_z(flag_z),
    .err(err), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_da = rf[rf_ra];
  assign rf_db = rf[rf_rb];

  // external ALU: returns {o,c,s,z,result}
  function automatic logic [19:0] alu(input logic [7:0] op,
                                      input logic [15:0] a,
                                      input logic [15:0] b);
    logic [15:0] r;
    logic c, o;
    c = 1'b0;
    o = 1'b0;
    case (op[4:0])
      5'd0: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        o = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'd1: begin
        {c, r} = {1'b0, a} - {1'b0, b};
        o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      5'd2:    r = a & b;
      5'd3:    r = a | b;
      5'd4:    r = a ^ b;
      default: r = a;
    endcase
    return {o, c, r[15], (r == 16'd0), r};
  endfunction

  logic [19:0] alu_out;
  always_comb begin
    alu_out  = alu(ula_op, ula_a, ula_b);
    ula_resu = alu_out[15:0];
    {ula_o, ula_c, ula_s, ula_z} = alu_out[19:16];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: phase = cycles elapsed since acceptance (0 = idle).
  int          m_phase;
  logic        m_err;
  logic [3:0]  m_flags;
  logic [15:0] m_cnt;
  logic [7:0]  t_op;
  logic [3:0]  t_ra, t_rb, t_rd;
  logic [15:0] t_const;
  logic [15:0] m_a, m_b, m_res;
  logic [7:0]  m_uop;
  logic [19:0] m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_err   = 1'b0;
      m_flags = '0;
      m_cnt   = '0;
    end else begin
      m_err = 1'b0;
      case (m_phase)
        0: if (in_valid) begin
          if (in_op[7:6] == 2'b11) m_err = 1'b1;
          else begin
            t_op = in_op; t_ra = in_ra; t_rb = in_rb;
            t_rd = in_rd; t_const = in_const;
            m_phase = 1;
          end
        end
        1: begin
          m_a = rf[t_ra];
          m_b = (t_op[7:6] == 2'b10) ? rf[t_rb] : t_const;
          m_uop = t_op;
          m_phase = 2;
        end
        2: begin
          m_r = alu(m_uop, m_a, m_b);
          m_res = m_r[15:0];
          if (t_op[7:6] == 2'b10) m_flags = m_r[19:16];
          m_phase = 3;
        end
        default: if (wb_ready) begin
          m_cnt = m_cnt + 16'd1;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("wb_valid", wb_valid, m_phase == 3);
      chk("err", err, m_err);
      chk("flags", {flag_o, flag_c, flag_s, flag_z}, m_flags);
      chk("op_count", op_count, m_cnt);
      if (m_phase == 1) begin
        chk("rf_ra", rf_ra, t_ra);
        chk("rf_rb", rf_rb, t_rb);
      end
      if (m_phase >= 2) begin
        chk("ula_a", ula_a, m_a);
        chk("ula_b", ula_b, m_b);
        chk("ula_op", ula_op, m_uop);
      end
      if (m_phase == 3) begin
        chk("wb_rd", wb_rd, t_rd);
        chk("wb_data", wb_data, m_res);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_ula_a", ula_a, 0);
    chk("rst_ula_b", ula_b, 0);
    chk("rst_ula_op", ula_op, 0);
    chk("rst_rf_ra", rf_ra, 0);
    chk("rst_rf_rb", rf_rb, 0);
    chk("rst_flags", {flag_o, flag_c, flag_s, flag_z}, 0);
    chk("rst_err", err, 0);
    chk("rst_op_count", op_count, 0);
  endtask

  // called at a negedge; returns at the negedge after acceptance (READ)
  task automatic send(input logic [7:0] op, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [3:0] rd,
                      input logic [15:0] c);
    int n;
    n = 0;
    in_op = op; in_ra = ra; in_rb = rb; in_rd = rd; in_const = c;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = '0; in_ra = '0; in_rb = '0; in_rd = '0; in_const = '0;
    wb_ready = 1'b1;
    for (int i = 0; i < 16; i++) rf[i] = 16'(i * 16'h1111);
    rf[1] = 16'h7FFF;
    rf[2] = 16'h0001;
    #12 check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    // add 7FFF + 0001 into r3
    send(8'b10_0_00000, 4'd1, 4'd2, 4'd3, 16'h0);
    @(negedge clk);
    chk("lat_exec_wbv", wb_valid, 0);
    @(negedge clk);
    chk("lat_wb_wbv", wb_valid, 1);
    chk("add_data", wb_data, 16'h8000);
    chk("add_rd", wb_rd, 3);
    chk("add_flags", {flag_o, flag_s, flag_z}, 3'b110);
    @(negedge clk);
    chk("add_count", op_count, 1);
    chk("add_wbv_off", wb_valid, 0);

    // constant-operand format keeps flags
    send(8'b00_0_00011, 4'd1, 4'd0, 4'd4, 16'h00F0);
    @(negedge clk);
    chk("const_ula_b", ula_b, 16'h00F0);
    @(negedge clk);
    chk("const_data", wb_data, 16'h7FFF);
    @(negedge clk);
    chk("const_flags", {flag_o, flag_s, flag_z}, 3'b110);
    chk("const_count", op_count, 2);

    // writeback stall with junk offered on the input
    wb_ready = 1'b0;
    send(8'b10_0_00000, 4'd2, 4'd2, 4'd7, 16'h0);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = 8'h80;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wbv", wb_valid, 1);
      chk("stall_ready", in_ready, 0);
      chk("stall_rd", wb_rd, 7);
      chk("stall_data", wb_data, 16'h0002);
    end
    wb_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_count", op_count, 3);

    // illegal format
    in_op = 8'hC5;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ill_err", err, 1);
    chk("ill_ready", in_ready, 1);
    @(negedge clk);
    chk("ill_err_off", err, 0);
    chk("ill_count", op_count, 3);
    chk("ill_wbv", wb_valid, 0);

    // reset while in EXEC
    send(8'b10_0_00000, 4'd1, 4'd2, 4'd5, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_wbv", wb_valid, 0);
    end

    // randomized traffic
    repeat (4000) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      in_op[7:6] = 2'($urandom_range(0, 3));
      in_op[5] = 1'($urandom_range(0, 1));
      in_op[4:0] = 5'($urandom_range(0, 5));
      in_ra = 4'($urandom_range(0, 15));
      in_rb = 4'($urandom_range(0, 15));
      in_rd = 4'($urandom_range(0, 15));
      in_const = 16'($urandom);
      wb_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 15)] = 16'($urandom);
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_issue.md
ULA_ISSUE -- requirements
Module: ula_issue

Interface
REQ-001 Parameter bits, default 16, data width of operands, result and constant.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  instruction offered; in_ready  output  1  block accepts instruction.
REQ-005 in_op  input  8  operation code: [7:6] format, [5] R, [4:0] arith/logic op; in_ra, in_rb, in_rd  input  4 each  source A, source B, destination register.
REQ-006 in_const  input  bits  constant operand.
REQ-007 rf_ra, rf_rb  output  4 each  register-bank read addresses; rf_da, rf_db  input  bits each  read data, combinational, valid same cycle.
REQ-008 ula_a, ula_b  output  bits each; ula_op  output  8; operands and opcode driven to the ALU.
REQ-009 ula_resu  input  bits; ula_o, ula_c, ula_s, ula_z  input  1 each; ALU result and flags, combinational from ula_a/ula_b/ula_op.
REQ-010 wb_valid  output  1; wb_ready  input  1; wb_rd  output  4; wb_data  output  bits; writeback handshake.
REQ-011 flag_o, flag_c, flag_s, flag_z  output  1 each  architectural flag register.
REQ-012 err  output  1  one-cycle pulse on illegal format; op_count  output  16  completed-instruction counter.

Function
REQ-013 FSM states IDLE, READ, EXEC, WB; IDLE after reset.
REQ-014 IDLE: in_ready=1; on in_valid=1 latch in_op, in_ra, in_rb, in_rd, in_const, go READ; in_ready=0 in all other states.
REQ-015 IDLE with in_op[7:6]==2'b11 accepted: err=1 for the next cycle, no register read, no writeback, flags and op_count unchanged, stay IDLE.
REQ-016 READ: rf_ra=latched ra, rf_rb=latched rb; capture A=rf_da; capture B=rf_db if format==2'b10, else B=latched in_const; go EXEC.
REQ-017 ula_a, ula_b, ula_op driven from the captured A, B, opcode registers and held constant through EXEC and WB.
REQ-018 EXEC: capture ula_resu into wb_data register; go WB.
REQ-019 EXEC with format==2'b10: flag register loads ula_o, ula_c, ula_s, ula_z at the same edge; other formats leave flags unchanged.
REQ-020 WB: wb_valid=1, wb_rd=latched rd, wb_data stable; stay in WB while wb_ready=0.
REQ-021 WB with wb_ready=1: handshake completes, op_count increments, return IDLE; wb_valid deasserts next cycle.
REQ-022 No back-to-back acceptance: new instruction accepted only in IDLE; minimum issue interval 4 cycles (accept, READ, EXEC, WB with wb_ready=1).
REQ-023 Latency: instruction accepted at edge N, wb_valid=1 from cycle after edge N+2.
REQ-024 op_count wraps 16'hFFFF -> 16'h0000 without side effect.
REQ-025 in_valid deasserted in IDLE: no state change, outputs hold.
REQ-026 Register addresses 0..15 all legal; rd==ra or rd==rb requires no special handling (reads complete before writeback).

Reset
REQ-027 rst_n=0 forces IDLE immediately, independent of clk, including mid-READ/EXEC/WB; in-flight instruction discarded.
REQ-028 Reset values: in_ready=1, wb_valid=0, wb_rd=0, wb_data=0, ula_a=0, ula_b=0, ula_op=0, rf_ra=0, rf_rb=0, flags all 0, err=0, op_count=0.
REQ-029 After rst_n rises, first instruction accepted on first rising edge with in_valid=1.

Verification
REQ-030 R1=16'h7FFF, R2=16'h0001, op format 2'b10 add, rd=3, wb_ready=1 -> wb_valid after 3 cycles, wb_data=16'h8000, wb_rd=3, flag_o=1, flag_s=1, flag_z=0, op_count=1.
REQ-031 Format 2'b00 op with in_const=16'h00F0, flags previously set by add -> B=16'h00F0 on ula_b, flags unchanged after completion.
REQ-032 wb_ready held 0 for 5 cycles in WB -> wb_valid, wb_rd, wb_data, ula_* stable, in_ready=0, in_valid ignored; releases on wb_ready=1.
REQ-033 in_op[7:6]=2'b11 -> err pulses 1 cycle, no wb_valid, op_count and flags unchanged, next instruction accepted normally.
REQ-034 rst_n=0 asserted mid-EXEC -> all outputs at reset values same cycle, no writeback of the aborted instruction.
REQ-035 op_count preloaded to 16'hFFFF by 65535 completions -> next completion yields 16'h0000.
